// File: rtl/phase_shift_applier.sv
// Slews a running phase offset toward a requested shift in bounded per-clock steps.
// Optional PHASE_SHIFT_SIGNED_EN: treat phase_shift as two's complement (shortest-path slew).
module phase_shift_applier #(
    parameter logic [31:0] STEP = 32'h0100_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] phase_shift,
    input  logic        clear,
    output logic [31:0] phase_offset,
    output logic        busy,
    output logic        done,
    output logic        overrun
);

    typedef enum logic [1:0] {IDLE, LOAD, SLEW, DONE} state_e;

    state_e      state_q, state_d;
    logic [31:0] shadow_q, shadow_d;
    logic [32:0] rem_q, rem_d;
    logic        dir_q, dir_d;      // 1 = backward
    logic [31:0] offset_q, offset_d;
    logic        overrun_q, overrun_d;

    logic [32:0] step_amt;
    logic [32:0] load_mag;
    logic        load_dir;

    // 33-bit magnitude so a signed 0x8000_0000 maps to 2^31 without overflow
`ifdef PHASE_SHIFT_SIGNED_EN
    assign load_dir = shadow_q[31];
    assign load_mag = shadow_q[31] ? {1'b0, 32'(~shadow_q + 32'd1)} : {1'b0, shadow_q};
`else
    assign load_dir = 1'b0;
    assign load_mag = {1'b0, shadow_q};
`endif

    assign step_amt = (rem_q < {1'b0, STEP}) ? rem_q : {1'b0, STEP};

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        rem_d     = rem_q;
        dir_d     = dir_q;
        offset_d  = offset_q;
        overrun_d = 1'b0;
        if (clear) begin
            offset_d = 32'd0;
            state_d  = IDLE;
            rem_d    = 33'd0;
            dir_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        shadow_d = phase_shift;
                        state_d  = LOAD;
                    end else begin
                        state_d  = IDLE;
                    end
                end
                LOAD: begin
                    overrun_d = start;
                    dir_d     = load_dir;
                    rem_d     = load_mag;
                    state_d   = (load_mag == 33'd0) ? DONE : SLEW;
                end
                SLEW: begin
                    overrun_d = start;
                    offset_d  = dir_q ? (offset_q - step_amt[31:0]) : (offset_q + step_amt[31:0]);
                    rem_d     = rem_q - step_amt;
                    if (rem_q == step_amt) state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            shadow_q  <= 32'd0;
            rem_q     <= 33'd0;
            dir_q     <= 1'b0;
            offset_q  <= 32'd0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            rem_q     <= rem_d;
            dir_q     <= dir_d;
            offset_q  <= offset_d;
            overrun_q <= overrun_d;
        end
    end

    assign phase_offset = offset_q;
    assign busy         = (state_q == LOAD) || (state_q == SLEW);
    assign done         = (state_q == DONE);
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_phase_shift_applier.sv
// Directed bench for phase_shift_applier with hand-computed offsets and latencies.
module tb_phase_shift_applier;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] phase_shift = 32'd0;
    logic        clear = 1'b0;
    logic [31:0] phase_offset;
    logic        busy, done, overrun;

    int checks = 0;
    int failures = 0;

    phase_shift_applier #(.STEP(32'h0100_0000)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .phase_shift(phase_shift),
        .clear(clear), .phase_offset(phase_offset), .busy(busy), .done(done),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns just after edge k, with start already scheduled to drop.
    task automatic pulse_start(input logic [31:0] val);
        @(negedge clk);
        start = 1'b1;
        phase_shift = val;
        tick();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        tick();
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic run_shift(input string tag, input logic [31:0] val, input logic [31:0] first,
                             input int n_slew, input logic [31:0] final_off);
        int cyc;
        pulse_start(val);
        tick();                       // k+1: LOAD
        tick();                       // k+2: first update
        chk({tag, "_first"}, phase_offset, first);
        cyc = 1;
        while (!done && cyc < 1000) begin
            tick();
            cyc++;
        end
        chk({tag, "_slew_cycles"}, 32'(cyc), 32'(n_slew));
        chk({tag, "_final"}, phase_offset, final_off);
        tick();
        chk({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_offset", phase_offset, 32'd0);
        chk("rst_flags", {29'd0, busy, done, overrun}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Forward multi-step, edge-by-edge
        pulse_start(32'h0280_0000);
        chk("fwd_busy_load", {31'd0, busy}, 32'd1);
        tick();
        chk("fwd_k1", phase_offset, 32'd0);
        tick();
        chk("fwd_k2", phase_offset, 32'h0100_0000);
        tick();
        chk("fwd_k3", phase_offset, 32'h0200_0000);
        chk("fwd_busy_k3", {30'd0, busy, done}, 32'b10);
        tick();
        chk("fwd_k4", phase_offset, 32'h0280_0000);
        chk("fwd_done_k4", {30'd0, busy, done}, 32'b01);
        tick();
        chk("fwd_done_gone", {31'd0, done}, 32'd0);

        // Negative shift and half-turn, each from zero
        do_clear();
        chk("clear_idle", phase_offset, 32'd0);
`ifdef PHASE_SHIFT_SIGNED_EN
        run_shift("neg", 32'hFD80_0000, 32'hFF00_0000, 3, 32'hFD80_0000);
        do_clear();
        run_shift("half", 32'h8000_0000, 32'hFF00_0000, 128, 32'h8000_0000);
`else
        run_shift("neg", 32'hFD80_0000, 32'h0100_0000, 254, 32'hFD80_0000);
        do_clear();
        run_shift("half", 32'h8000_0000, 32'h0100_0000, 128, 32'h8000_0000);
`endif
        // Sub-step shift accumulates on top of existing offset
        run_shift("small", 32'h0000_0080, 32'h8000_0080, 1, 32'h8000_0080);

        // Zero shift: done right after LOAD, offset unchanged
        pulse_start(32'd0);
        tick();
        chk("zero_done", {30'd0, busy, done}, 32'b01);
        chk("zero_offset", phase_offset, 32'h8000_0080);
        tick();
        chk("zero_done_gone", {31'd0, done}, 32'd0);

        // Overrun: second start during SLEW is ignored
        do_clear();
        pulse_start(32'h0280_0000);
        tick();                       // k+1
        @(negedge clk);
        start = 1'b1;
        phase_shift = 32'h1000_0000;
        tick();                       // k+2
        chk("ovr_pulse", {31'd0, overrun}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        tick();                       // k+3
        chk("ovr_one_cycle", {31'd0, overrun}, 32'd0);
        tick();                       // k+4
        chk("ovr_final", phase_offset, 32'h0280_0000);
        chk("ovr_done", {31'd0, done}, 32'd1);

        // Clear beats a simultaneous start mid-slew
        pulse_start(32'h0280_0000);
        tick();
        tick();                       // k+2, in SLEW
        @(negedge clk);
        clear = 1'b1;
        start = 1'b1;
        tick();
        chk("clr_offset", phase_offset, 32'd0);
        chk("clr_flags", {29'd0, busy, done, overrun}, 32'd0);
        @(negedge clk);
        clear = 1'b0;
        start = 1'b0;
        tick();
        chk("clr_still_idle", {29'd0, busy, done, overrun}, 32'd0);
        run_shift("after_clr", 32'h0100_0000, 32'h0100_0000, 1, 32'h0100_0000);

        // Asynchronous reset mid-slew
        pulse_start(32'h0280_0000);
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_offset", phase_offset, 32'd0);
        chk("arst_flags", {29'd0, busy, done, overrun}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
